// File: rtl/tea_cipher_core_if.sv
// Stream (req/ready/valid) and host configuration signals of the TEA engine.
// The master side is the source/sink plus host; the slave side is the core.
interface tea_cipher_core_if #(
  parameter int W = 32
);
  logic           req;
  logic           mode;
  logic [2*W-1:0] wdata;
  logic           ready;
  logic           valid;
  logic [2*W-1:0] rdata;
  logic           busy;
  logic           cfg_we;
  logic [2:0]     cfg_addr;
  logic [W-1:0]   cfg_wdata;
  logic [W-1:0]   cfg_rdata;

  modport master (
    output req, mode, wdata, cfg_we, cfg_addr, cfg_wdata,
    input  ready, valid, rdata, busy, cfg_rdata
  );

  modport slave (
    input  req, mode, wdata, cfg_we, cfg_addr, cfg_wdata,
    output ready, valid, rdata, busy, cfg_rdata
  );
endinterface

// File: rtl/tea_cipher_core.sv
// Iterative TEA encrypt/decrypt engine, one round per clock, with a small
// register file for key, delta and round count.
//
// state | meaning
// IDLE  | ready for a block; ready=1
// RUN   | rounds in progress; busy=1, config writes to 0..5 locked out
module tea_cipher_core #(
  parameter int           W      = 32,
  parameter logic [127:0] KEY    = 128'h0,
  parameter logic [31:0]  DELTA  = 32'h9E3779B9,
  parameter int           ROUNDS = 32,
  parameter int           SHL    = 4,
  parameter int           SHR    = 5
) (
  input logic              clk,
  input logic              rst,
  tea_cipher_core_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state;
  logic           ready_q;
  logic           valid_q;
  logic           busy_q;
  logic [2*W-1:0] rdata_q;

  logic [W-1:0] k0, k1, k2, k3, delta;
  logic [7:0]   rounds;
  logic         wr_err;

  logic [W-1:0] v0, v1, sum;
  logic [7:0]   count;
  logic         dec;

  logic [W-1:0] enc_sum, enc_v0, enc_v1;
  logic [W-1:0] dec_sum, dec_v0, dec_v1;
  logic [W-1:0] nxt_v0, nxt_v1, nxt_sum;
  logic [W-1:0] rounds_ext, sum_init;

  function automatic logic [W-1:0] mix(input logic [W-1:0] v, input logic [W-1:0] s,
                                       input logic [W-1:0] ka, input logic [W-1:0] kb);
    return ((v << SHL) + ka) ^ (v + s) ^ ((v >> SHR) + kb);
  endfunction

  always_comb begin
    enc_sum    = sum + delta;
    enc_v0     = v0 + mix(v1, enc_sum, k0, k1);
    enc_v1     = v1 + mix(enc_v0, enc_sum, k2, k3);
    dec_v1     = v1 - mix(v0, sum, k2, k3);
    dec_v0     = v0 - mix(dec_v1, sum, k0, k1);
    dec_sum    = sum - delta;
    nxt_v0     = dec ? dec_v0 : enc_v0;
    nxt_v1     = dec ? dec_v1 : enc_v1;
    nxt_sum    = dec ? dec_sum : enc_sum;
    rounds_ext = W'(rounds);
    // decryption walks the sum back down from its final encrypt value
    sum_init   = delta * rounds_ext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
      v0      <= '0;
      v1      <= '0;
      sum     <= '0;
      count   <= '0;
      dec     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            v0      <= bus.wdata[W-1:0];
            v1      <= bus.wdata[2*W-1:W];
            dec     <= bus.mode;
            count   <= rounds;
            sum     <= bus.mode ? sum_init : '0;
            state   <= RUN;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          v0    <= nxt_v0;
          v1    <= nxt_v1;
          sum   <= nxt_sum;
          count <= count - 8'd1;
          if (count == 8'd1) begin
            rdata_q <= {nxt_v1, nxt_v0};
            valid_q <= 1'b1;
            state   <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k0     <= KEY[W-1:0];
      k1     <= KEY[2*W-1:W];
      k2     <= KEY[3*W-1:2*W];
      k3     <= KEY[4*W-1:3*W];
      delta  <= DELTA[W-1:0];
      rounds <= 8'(ROUNDS);
      wr_err <= 1'b0;
    end else if (bus.cfg_we) begin
      if (bus.cfg_addr <= 3'd5 && busy_q) begin
        wr_err <= 1'b1;
      end else begin
        case (bus.cfg_addr)
          3'd0: k0 <= bus.cfg_wdata;
          3'd1: k1 <= bus.cfg_wdata;
          3'd2: k2 <= bus.cfg_wdata;
          3'd3: k3 <= bus.cfg_wdata;
          3'd4: delta <= bus.cfg_wdata;
          3'd5: if (bus.cfg_wdata[7:0] != 8'd0) rounds <= bus.cfg_wdata[7:0];
          3'd6: wr_err <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus.cfg_rdata = '0;
    case (bus.cfg_addr)
      3'd0: bus.cfg_rdata = k0;
      3'd1: bus.cfg_rdata = k1;
      3'd2: bus.cfg_rdata = k2;
      3'd3: bus.cfg_rdata = k3;
      3'd4: bus.cfg_rdata = delta;
      3'd5: bus.cfg_rdata = rounds_ext;
      3'd6: bus.cfg_rdata = {{(W-2){1'b0}}, wr_err, busy_q};
      default: bus.cfg_rdata = '0;
    endcase
  end

  assign bus.ready = ready_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_tea_cipher_core.sv
// Bench for tea_cipher_core: directed stimulus pushes expected blocks into a
// scoreboard; a negedge monitor pops and checks them on every valid pulse.
module tb_tea_cipher_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tea_cipher_core_if #(.W(32)) bus ();
  tea_cipher_core #(.W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [63:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [127:0] cur_key = 128'h0;
  logic [31:0]  cur_delta = 32'h9E3779B9;
  int           cur_rounds = 32;

  always @(posedge clk) cyc++;

  function automatic logic [63:0] tea_ref(input logic [63:0] blk, input logic [127:0] k,
                                          input logic [31:0] d, input int n, input bit decr);
    logic [31:0] a, b, s, k0, k1, k2, k3;
    a = blk[31:0]; b = blk[63:32];
    k0 = k[31:0]; k1 = k[63:32]; k2 = k[95:64]; k3 = k[127:96];
    if (!decr) begin
      s = 32'h0;
      for (int i = 0; i < n; i++) begin
        s = s + d;
        a = a + (((b << 4) + k0) ^ (b + s) ^ ((b >> 5) + k1));
        b = b + (((a << 4) + k2) ^ (a + s) ^ ((a >> 5) + k3));
      end
    end else begin
      s = d * 32'(n);
      for (int i = 0; i < n; i++) begin
        b = b - (((a << 4) + k2) ^ (a + s) ^ ((a >> 5) + k3));
        a = a - (((b << 4) + k0) ^ (b + s) ^ ((b >> 5) + k1));
        s = s - d;
      end
    end
    return {b, a};
  endfunction

  // A block accepted on edge number c0 must show valid while cyc == c0 + rounds.
  bit prev_valid = 1'b0;
  always @(negedge clk) begin
    if (!rst && bus.valid) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_valid: got rdata=%h, no block outstanding", bus.rdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        total++;
        if (bus.rdata !== e.data) begin
          bad++;
          $display("FAIL rdata: got %h expected %h", bus.rdata, e.data);
        end
        total++;
        if (cyc != e.due) begin
          bad++;
          $display("FAIL latency: valid at cycle %0d expected %0d", cyc, e.due);
        end
      end
      total++;
      if (prev_valid || bus.ready !== 1'b1) begin
        bad++;
        $display("FAIL valid_pulse: prev_valid=%0b ready=%0b expected 0/1", prev_valid, bus.ready);
      end
    end
    prev_valid = bus.valid;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_reg(input logic [2:0] a, input logic [31:0] exp, input string name);
    bus.cfg_addr = a;
    #1;
    check(name, 64'(bus.cfg_rdata), 64'(exp));
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
    bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_wdata = d;
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  task automatic set_key(input logic [127:0] k);
    for (int i = 0; i < 4; i++) cfg_write(3'(i), k[32*i +: 32]);
    cur_key = k;
  endtask

  // Raises req, waits for ready, pushes the expectation; leaves req high.
  task automatic send(input bit m, input logic [63:0] d, input logic [63:0] exp, output int c0);
    int guard = 0;
    exp_t e;
    bus.req = 1'b1; bus.mode = m; bus.wdata = d;
    while (bus.ready !== 1'b1 && guard < 1000) begin
      @(negedge clk); guard++;
    end
    if (guard >= 1000) begin
      total++; bad++;
      $display("FAIL ready_timeout: ready never rose, got %0b expected 1", bus.ready);
    end
    @(negedge clk);
    c0 = cyc;
    e.data = exp; e.due = c0 + cur_rounds;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((sb.size() != 0 || bus.ready !== 1'b1) && guard < 2000) begin
      @(negedge clk); guard++;
    end
    if (guard >= 2000) begin
      total++; bad++;
      $display("FAIL idle_timeout: %0d blocks outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int c0, c1, c2;
    logic [63:0] p, c;
    logic [127:0] k;
    bus.req = 1'b0; bus.mode = 1'b0; bus.wdata = '0;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_ready", 64'(bus.ready), 64'd1);
    check("rst_valid", 64'(bus.valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_rdata", bus.rdata, 64'h0);
    rst = 1'b0;
    @(negedge clk);
    check_reg(3'd0, 32'h0, "rst_k0");
    check_reg(3'd4, 32'h9E3779B9, "rst_delta");
    check_reg(3'd5, 32'd32, "rst_rounds");
    check_reg(3'd6, 32'd0, "rst_status");
    cfg_write(3'd7, 32'hFFFF_FFFF);
    check_reg(3'd7, 32'd0, "addr7_read");

    // zero-key vector and its inverse
    set_key(128'h0);
    cfg_write(3'd4, 32'h9E3779B9);
    cfg_write(3'd5, 32'd32);
    send(1'b0, 64'h0, 64'h94BAA940_41EA3A0A, c0);
    send(1'b1, 64'h94BAA940_41EA3A0A, 64'h0, c1);
    bus.req = 1'b0;
    wait_idle();

    // back-to-back, req held high across three blocks
    send(1'b0, 64'h0123_4567_89AB_CDEF, tea_ref(64'h0123_4567_89AB_CDEF, cur_key, cur_delta, 32, 0), c0);
    send(1'b0, 64'hFFFF_FFFF_0000_0001, tea_ref(64'hFFFF_FFFF_0000_0001, cur_key, cur_delta, 32, 0), c1);
    check("ready_mid_run", 64'(bus.ready), 64'd0);
    send(1'b1, 64'hCAFE_F00D_1234_5678, tea_ref(64'hCAFE_F00D_1234_5678, cur_key, cur_delta, 32, 1), c2);
    bus.req = 1'b0;
    check("b2b_gap1", 64'(c1 - c0), 64'd33);
    check("b2b_gap2", 64'(c2 - c1), 64'd33);
    wait_idle();

    // config lockout: write during busy dropped, wr_err sticky until addr 6 write
    k = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    set_key(k);
    p = 64'h1111_2222_3333_4444;
    send(1'b0, p, tea_ref(p, k, cur_delta, 32, 0), c0);
    bus.req = 1'b0;
    repeat (3) @(negedge clk);
    cfg_write(3'd0, 32'hDEADBEEF);
    check_reg(3'd6, 32'd3, "status_locked");
    wait_idle();
    check_reg(3'd0, k[31:0], "k0_unchanged");
    cfg_write(3'd6, 32'd0);
    check_reg(3'd6, 32'd0, "status_cleared");

    // round trips with random keys and blocks
    for (int i = 0; i < 100; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom};
      set_key(k);
      c = tea_ref(p, k, cur_delta, 32, 0);
      send(1'b0, p, c, c0);
      send(1'b1, c, p, c1);
      bus.req = 1'b0;
      wait_idle();
    end

    // rounds boundaries
    cfg_write(3'd5, 32'd1);
    cur_rounds = 1;
    p = 64'hA5A5_5A5A_0F0F_F0F0;
    send(1'b0, p, tea_ref(p, cur_key, cur_delta, 1, 0), c0);
    bus.req = 1'b0;
    wait_idle();
    cfg_write(3'd5, 32'd0);
    check_reg(3'd5, 32'd1, "rounds_zero_ignored");
    cfg_write(3'd5, 32'd255);
    cur_rounds = 255;
    check_reg(3'd5, 32'd255, "rounds_255");
    c = tea_ref(p, cur_key, cur_delta, 255, 0);
    send(1'b0, p, c, c0);
    send(1'b1, c, p, c1);
    bus.req = 1'b0;
    wait_idle();

    // reset mid-run
    cfg_write(3'd5, 32'd32);
    cur_rounds = 32;
    cfg_write(3'd4, 32'h1234_5678);
    cur_delta = 32'h1234_5678;
    send(1'b0, p, tea_ref(p, cur_key, cur_delta, 32, 0), c0);
    bus.req = 1'b0;
    repeat (9) @(negedge clk);
    sb.delete();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ready", 64'(bus.ready), 64'd1);
    check("midrst_valid", 64'(bus.valid), 64'd0);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_rdata", bus.rdata, 64'h0);
    rst = 1'b0;
    cur_key = 128'h0; cur_delta = 32'h9E3779B9;
    check_reg(3'd1, 32'h0, "midrst_k1");
    check_reg(3'd4, 32'h9E3779B9, "midrst_delta");
    check_reg(3'd5, 32'd32, "midrst_rounds");
    check_reg(3'd6, 32'd0, "midrst_status");
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench still running at %0t, expected done", $time);
    $fatal(1, "timeout");
  end
endmodule
